// File: rtl/pll_lock_ctrl.sv
// -----------------------------------------------------------------------------
// pll_lock_ctrl
//
// Reset/lock sequencer for the core PLL. Pulses the PLL reset, waits for the
// PLL lock indication to be stable for a filtered number of cycles, and only
// then releases the downstream core reset. Each acquisition attempt is bounded
// by a timeout. A bounded number of retries follow before the block parks in
// a failed state until relock_req or rst.
//
// Parameters:
//   RST_CYCLES   - cycles pll_rst is held high per attempt (>= 2)
//   LOCK_FILTER  - consecutive synchronized-lock cycles required for release (>= 1)
//   LOCK_TIMEOUT - cycles allowed from pll_rst deassert to filtered lock
//   MAX_RETRY    - retries after the first attempt before declaring failure
//
// Ports:
//   refclk        in   reference clock; all logic on its rising edge
//   rst           in   asynchronous active-high reset
//   locked_in     in   raw PLL lock, asynchronous (2-flop synchronized here)
//   relock_req    in   single-cycle request to restart acquisition
//   pll_rst       out  PLL reset, active-high
//   sys_rst       out  downstream core reset, active-high
//   ready         out  lock filtered, core running
//   fail          out  all attempts exhausted
//   retry_cnt     out  retries taken in the current acquisition
//
// Optional build macro PLL_LOCK_STATUS_EN adds:
//   lock_loss_cnt out  8-bit saturating count of lock losses while running
//                      (cleared only by rst)
//   lock_s_dbg    out  synchronized lock
// -----------------------------------------------------------------------------
module pll_lock_ctrl #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_FILTER  = 1024,
    parameter int LOCK_TIMEOUT = 500000,
    parameter int MAX_RETRY    = 3,
    localparam int RETRY_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               locked_in,
    input  logic               relock_req,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt
`ifdef PLL_LOCK_STATUS_EN
    ,
    output logic [7:0]         lock_loss_cnt,
    output logic               lock_s_dbg
`endif
);

    localparam int RST_W = $clog2(RST_CYCLES);
    localparam int FLT_W = (LOCK_FILTER  > 1) ? $clog2(LOCK_FILTER)  : 1;
    localparam int TMO_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [FLT_W-1:0]   FLT_LAST  = FLT_W'(LOCK_FILTER - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_FILTER,
        S_RUN,
        S_FAILED
    } state_t;

    // Registers
    logic [1:0]         r_sync;
    state_t             r_state;
    logic [RST_W-1:0]   r_rst_cnt;
    logic [FLT_W-1:0]   r_flt_cnt;
    logic [TMO_W-1:0]   r_tmr;
    logic [RETRY_W-1:0] r_retry;
    logic               r_pll_rst;
    logic               r_sys_rst;
    logic               r_ready;
    logic               r_fail;

    // Next-state / combinational
    state_t             w_state_nxt;
    logic [RST_W-1:0]   w_rst_cnt_nxt;
    logic [FLT_W-1:0]   w_flt_cnt_nxt;
    logic [TMO_W-1:0]   w_tmr_nxt;
    logic [RETRY_W-1:0] w_retry_nxt;
    logic               w_lock_s;
    logic               w_timeout;
    logic               w_flt_done;
    logic [TMO_W-1:0]   w_tmr_inc;
    state_t             w_tmo_state;
    logic [RETRY_W-1:0] w_tmo_retry;
    logic               w_lock_loss;

    // ---------------------------------------------------------------------
    // Lock synchronizer
    // ---------------------------------------------------------------------
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of its neighbours; blocking = here would collapse
    // the two synchronizer stages into one.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], locked_in};
        end
    end

    assign w_lock_s = r_sync[1];

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    assign w_timeout  = (r_tmr == TMO_LAST);
    assign w_flt_done = w_lock_s && (r_flt_cnt == FLT_LAST);
    // The timer holds at its terminal value rather than wrapping.
    assign w_tmr_inc  = w_timeout ? r_tmr : r_tmr + 1'b1;

    // Outcome of a timeout: another attempt while retries remain, else park.
    assign w_tmo_state = (r_retry < RETRY_MAX) ? S_RESET_PLL : S_FAILED;
    assign w_tmo_retry = (r_retry < RETRY_MAX) ? r_retry + 1'b1 : r_retry;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_rst_cnt_nxt = r_rst_cnt;
        w_flt_cnt_nxt = r_flt_cnt;
        w_tmr_nxt     = r_tmr;
        w_retry_nxt   = r_retry;
        w_lock_loss   = 1'b0;

        if (relock_req) begin
            w_state_nxt   = S_RESET_PLL;
            w_rst_cnt_nxt = '0;
            w_flt_cnt_nxt = '0;
            w_tmr_nxt     = '0;
            w_retry_nxt   = '0;
        end else begin
            case (r_state)
                S_RESET_PLL: begin
                    // The entry cycle counts, so the state lasts RST_CYCLES cycles.
                    if (r_rst_cnt == RST_LAST) begin
                        w_state_nxt = S_WAIT_LOCK;
                        w_tmr_nxt   = '0;
                    end else begin
                        w_rst_cnt_nxt = r_rst_cnt + 1'b1;
                    end
                end

                S_WAIT_LOCK: begin
                    w_tmr_nxt = w_tmr_inc;
                    if (w_timeout) begin
                        w_state_nxt   = w_tmo_state;
                        w_retry_nxt   = w_tmo_retry;
                        w_rst_cnt_nxt = '0;
                    end else if (w_lock_s) begin
                        w_state_nxt   = S_FILTER;
                        w_flt_cnt_nxt = '0;
                    end
                end

                S_FILTER: begin
                    w_tmr_nxt = w_tmr_inc;
                    // Filter completion beats a coincident timeout.
                    if (w_flt_done) begin
                        w_state_nxt = S_RUN;
                        w_retry_nxt = '0;
                    end else if (w_timeout) begin
                        w_state_nxt   = w_tmo_state;
                        w_retry_nxt   = w_tmo_retry;
                        w_rst_cnt_nxt = '0;
                    end else if (!w_lock_s) begin
                        // The attempt timer keeps running across a lock glitch.
                        w_state_nxt   = S_WAIT_LOCK;
                        w_flt_cnt_nxt = '0;
                    end else begin
                        w_flt_cnt_nxt = r_flt_cnt + 1'b1;
                    end
                end

                S_RUN: begin
                    if (!w_lock_s) begin
                        w_state_nxt   = S_RESET_PLL;
                        w_rst_cnt_nxt = '0;
                        w_lock_loss   = 1'b1;
                    end
                end

                S_FAILED: begin
                    w_state_nxt = S_FAILED;
                end

                default: begin
                    w_state_nxt   = S_RESET_PLL;
                    w_rst_cnt_nxt = '0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // State, counters and registered outputs
    // ---------------------------------------------------------------------
    // Outputs are decoded from the next state so they change on the same
    // edge as the state register, without a combinational output path.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state   <= S_RESET_PLL;
            r_rst_cnt <= '0;
            r_flt_cnt <= '0;
            r_tmr     <= '0;
            r_retry   <= '0;
            r_pll_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_fail    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rst_cnt <= w_rst_cnt_nxt;
            r_flt_cnt <= w_flt_cnt_nxt;
            r_tmr     <= w_tmr_nxt;
            r_retry   <= w_retry_nxt;
            r_pll_rst <= (w_state_nxt == S_RESET_PLL) || (w_state_nxt == S_FAILED);
            r_sys_rst <= (w_state_nxt != S_RUN);
            r_ready   <= (w_state_nxt == S_RUN);
            r_fail    <= (w_state_nxt == S_FAILED);
        end
    end

    assign pll_rst   = r_pll_rst;
    assign sys_rst   = r_sys_rst;
    assign ready     = r_ready;
    assign fail      = r_fail;
    assign retry_cnt = r_retry;

`ifdef PLL_LOCK_STATUS_EN
    // Lock-loss statistics survive relock_req; only rst clears them.
    logic [7:0] r_loss_cnt;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_loss_cnt <= '0;
        end else if (w_lock_loss && (r_loss_cnt != 8'hFF) && !relock_req) begin
            r_loss_cnt <= r_loss_cnt + 1'b1;
        end
    end

    assign lock_loss_cnt = r_loss_cnt;
    assign lock_s_dbg    = w_lock_s;
`endif

endmodule
